cache_arbiter: RTL and testbench

- Arbitrates the split instruction cache and data cache onto the single cache-line memory port feeding the cacheline adaptor.
- Sits between the two L1 caches and the adaptor.
- Owns one full line transaction at a time and holds the grant until the adaptor responds.
- Steers response and read data back to the granted cache only.

---
 rtl/cache_arbiter.sv | 115 +++++++++++
 tb/tb_cache_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Round-robin arbiter that merges the split I/D L1 caches onto one line-wide
// memory port. It holds one grant per full transaction and returns each response only to its owner.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT_I = 2'd1;
  localparam logic [1:0] GRANT_D = 2'd2;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  logic [1:0] state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       i_req, d_req;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        // On a tie, serve the side that did not win last time.
        if (d_req && (!i_req || last_grant_q == LAST_I)) begin
          state_d      = GRANT_D;
          last_grant_d = LAST_D;
        end else if (i_req) begin
          state_d      = GRANT_I;
          last_grant_d = LAST_I;
        end
      end
      GRANT_I: if (mem_resp) state_d = IDLE;
      GRANT_D: if (mem_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Outputs decode from the state register, so an asynchronous reset clears them at once.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_rdata     = '0;
    i_resp      = 1'b0;
    d_rdata     = '0;
    d_resp      = 1'b0;
    case (state_q)
      GRANT_I: begin
        mem_read    = i_read;
        mem_address = i_address;
        i_rdata     = mem_rdata;
        i_resp      = mem_resp;
      end
      GRANT_D: begin
        // A write wins if the D-cache illegally raises both read and write.
        mem_read    = d_read & ~d_write;
        mem_write   = d_write;
        mem_address = d_address;
        mem_wdata   = d_wdata;
        d_rdata     = mem_rdata;
        d_resp      = mem_resp;
      end
      default: ;
    endcase
  end

`ifndef SYNTHESIS
  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(d_read && d_write))
    else $error("cache_arbiter: d_read and d_write asserted together");

  a_i_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == GRANT_I) |-> i_read)
    else $error("cache_arbiter: I-cache dropped request while granted");

  a_d_req_held: assert property (@(posedge clk) disable iff (rst)
    (state_q == GRANT_D) |-> (d_read || d_write))
    else $error("cache_arbiter: D-cache dropped request while granted");
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: reset, single-side transfers, round-robin,
// idle gaps, asynchronous reset mid-transaction and stray responses.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, mem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, mem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_resp, d_resp, mem_read, mem_write;
  logic [AW-1:0] mem_address;

  int checks   = 0;
  int failures = 0;

  localparam logic [LW-1:0] PAT_A5   = {32{8'hA5}};
  localparam logic [LW-1:0] PAT_1234 = {16{16'h1234}};
  localparam logic [LW-1:0] PAT_5A   = {32{8'h5A}};

  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so inputs can be driven and outputs sampled.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
    i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
    #2;
    check("rst_mem_read", LW'(mem_read), '0);
    check("rst_mem_write", LW'(mem_write), '0);
    check("rst_mem_address", LW'(mem_address), '0);
    check("rst_resp", LW'({i_resp, d_resp}), '0);
    step(); step();
    rst = 1'b0;

    // Single I-cache read
    i_read = 1; i_address = 32'h0000_0060; #1;
    check("t1_idle_no_req", LW'(mem_read), '0);
    step();
    check("t1_mem_read", LW'(mem_read), LW'(1));
    check("t1_mem_address", LW'(mem_address), LW'(32'h60));
    check("t1_no_i_resp_early", LW'(i_resp), '0);
    step();
    check("t1_hold", LW'(mem_read), LW'(1));
    mem_resp = 1; mem_rdata = PAT_A5; #1;
    check("t1_i_resp", LW'(i_resp), LW'(1));
    check("t1_i_rdata", i_rdata, PAT_A5);
    check("t1_d_resp", LW'(d_resp), '0);
    check("t1_d_rdata", d_rdata, '0);
    step();
    i_read = 0; mem_resp = 0; #1;
    check("t1_gap", LW'(mem_read), '0);
    check("t1_i_resp_after", LW'(i_resp), '0);

    // D-cache writeback
    d_write = 1; d_address = 32'h8000_0020; d_wdata = PAT_1234;
    step();
    check("t2_mem_write", LW'(mem_write), LW'(1));
    check("t2_mem_read", LW'(mem_read), '0);
    check("t2_mem_wdata", mem_wdata, PAT_1234);
    check("t2_mem_address", LW'(mem_address), LW'(32'h8000_0020));
    mem_resp = 1; mem_rdata = PAT_5A; #1;
    check("t2_d_resp", LW'(d_resp), LW'(1));
    check("t2_i_resp", LW'(i_resp), '0);
    step();
    d_write = 0; mem_resp = 0; #1;
    check("t2_gap", LW'({mem_read, mem_write}), '0);

    // Tie out of reset: D first, then I, then D again
    rst = 1; #2; rst = 0;
    i_read = 1; i_address = 32'h0000_1000;
    d_read = 1; d_address = 32'h0000_2000;
    step();
    check("t3_first_d", LW'(mem_address), LW'(32'h2000));
    check("t3_first_read", LW'(mem_read), LW'(1));
    mem_resp = 1; mem_rdata = PAT_A5; #1;
    check("t3_d_resp", LW'({i_resp, d_resp}), LW'(2'b01));
    check("t3_d_rdata", d_rdata, PAT_A5);
    step();
    mem_resp = 0; #1;
    check("t3_idle_gap", LW'(mem_read), '0);
    step();
    check("t3_second_i", LW'(mem_address), LW'(32'h1000));
    mem_resp = 1; mem_rdata = PAT_5A; #1;
    check("t3_i_resp", LW'({i_resp, d_resp}), LW'(2'b10));
    check("t3_i_rdata", i_rdata, PAT_5A);
    step();
    i_read = 0; mem_resp = 0; #1;
    check("t3_idle_gap2", LW'(mem_read), '0);
    step();
    check("t3_third_d", LW'(mem_address), LW'(32'h2000));
    mem_resp = 1; #1;
    check("t3_d_resp2", LW'(d_resp), LW'(1));
    step();
    d_read = 0; mem_resp = 0; #1;

    // Back-to-back I requests, one-cycle responses
    i_read = 1; i_address = 32'h0000_0300;
    step();
    check("t4_read_1", LW'(mem_read), LW'(1));
    mem_resp = 1; #1;
    check("t4_resp_1", LW'(i_resp), LW'(1));
    step();
    mem_resp = 0; #1;
    check("t4_read_0", LW'(mem_read), '0);
    check("t4_no_dup_resp", LW'(i_resp), '0);
    step();
    check("t4_read_1b", LW'(mem_read), LW'(1));
    check("t4_no_resp_yet", LW'(i_resp), '0);
    mem_resp = 1; #1;
    check("t4_resp_2", LW'(i_resp), LW'(1));
    step();
    i_read = 0; mem_resp = 0; #1;
    check("t4_end_gap", LW'(mem_read), '0);

    // Asynchronous reset during a D writeback
    d_write = 1; d_address = 32'h8000_0040; d_wdata = PAT_1234;
    step();
    check("t5_mem_write", LW'(mem_write), LW'(1));
    rst = 1; mem_resp = 1; #1;
    check("t5_async_write", LW'(mem_write), '0);
    check("t5_async_addr", LW'(mem_address), '0);
    check("t5_async_resp", LW'(d_resp), '0);
    mem_resp = 0; d_write = 0;
    step();
    rst = 0;
    d_read = 1; d_address = 32'h0000_0800; #1;
    check("t5_idle_after_rst", LW'(mem_read), '0);
    step();
    check("t5_regrant", LW'(mem_read), LW'(1));
    check("t5_regrant_addr", LW'(mem_address), LW'(32'h800));
    mem_resp = 1; #1;
    check("t5_d_resp", LW'(d_resp), LW'(1));
    step();
    d_read = 0; mem_resp = 0; #1;

    // Stray mem_resp while idle
    mem_resp = 1; #1;
    check("t6_stray_resp", LW'({i_resp, d_resp}), '0);
    step();
    check("t6_still_idle", LW'({mem_read, mem_write, i_resp, d_resp}), '0);
    mem_resp = 0;
    i_read = 1; i_address = 32'h0000_0040;
    step();
    check("t6_grant_after", LW'(mem_address), LW'(32'h40));
    mem_resp = 1;
    step();
    i_read = 0; mem_resp = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
